// File: rtl/if_fetch_unit_if.sv
// Instruction-memory port bundle for the fetch unit.
//   master (fetch unit): drives imem_req_valid/imem_req_addr,
//                        receives imem_req_ready and the in-order response.
//   slave  (memory)    : the mirror image.
interface if_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Issues word-aligned fetches on a pipelined valid/ready memory port, tracks
// in-flight PCs, buffers in-order responses and feeds PC/instruction to ID.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   PC_EN_IF                     allow new fetch requests
//   reg_FD_EN/stall/flush        IF/ID register control from hazard detection
//   redirect_valid/redirect_pc   taken branch/jump resolved in ID
//   imem                         memory request/response bundle (master side)
//   PC_ID/inst_ID/valid_ID       IF/ID register contents
//   fetch_bubble                 pulse: IF/ID loaded a bubble on an empty queue
module if_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   PC_EN_IF,
    input  logic                   reg_FD_EN,
    input  logic                   reg_FD_stall,
    input  logic                   reg_FD_flush,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            PC_ID,
    output logic [31:0]            inst_ID,
    output logic                   valid_ID,
    output logic                   fetch_bubble
);

    localparam int unsigned AW = $clog2(QDEPTH);
    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam int unsigned SW = CW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Fetch PC kept as a word address; the byte offset is always zero.
    logic [29:0]   r_pc_w;

    // In-flight request PCs, oldest first.
    logic [29:0]   r_pcf [QDEPTH];
    logic [AW-1:0] r_pcf_wp;
    logic [AW-1:0] r_pcf_rp;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop;

    // Instruction queue of returned {pc, inst} pairs.
    fetch_entry_t  r_iq [QDEPTH];
    logic [AW-1:0] r_iq_wp;
    logic [AW-1:0] r_iq_rp;
    logic [CW-1:0] r_qcount;

    // IF/ID register.
    logic [31:0]   r_pc_id;
    logic [31:0]   r_inst_id;
    logic          r_valid_id;
    logic          r_bubble;

    logic          w_room;
    logic          w_req_valid;
    logic          w_hs;
    logic          w_resp;
    logic          w_drop_active;
    logic          w_push;
    logic          w_qempty;
    logic          w_pop;
    logic [29:0]   w_resp_pcw;
    fetch_entry_t  w_push_entry;
    fetch_entry_t  w_head;
    logic          w_unused;

    // Capacity counts both outstanding requests and buffered instructions,
    // so every response always has a queue slot.
    assign w_room        = (SW'(r_inflight) + SW'(r_qcount)) < SW'(QDEPTH);
    assign w_req_valid   = rst_n & PC_EN_IF & ~redirect_valid & w_room;
    assign w_hs          = w_req_valid & imem.imem_req_ready;
    // A response with nothing outstanding is spurious and ignored.
    assign w_resp        = imem.imem_resp_valid & (r_inflight != '0);
    assign w_drop_active = (r_drop != '0);
    assign w_push        = w_resp & ~w_drop_active & ~redirect_valid;
    assign w_qempty      = (r_qcount == '0);
    assign w_pop         = ~reg_FD_flush & ~reg_FD_stall & reg_FD_EN & ~w_qempty;
    assign w_resp_pcw    = r_pcf[r_pcf_rp];
    assign w_push_entry  = '{pc: {w_resp_pcw, 2'b00}, inst: imem.imem_resp_data};
    assign w_head        = r_iq[r_iq_rp];
    assign w_unused      = ^redirect_pc[1:0];

    assign imem.imem_req_valid = w_req_valid;
    assign imem.imem_req_addr  = {r_pc_w, 2'b00};

    assign PC_ID        = r_pc_id;
    assign inst_ID      = r_inst_id;
    assign valid_ID     = r_valid_id;
    assign fetch_bubble = r_bubble;

    // Fetch PC, in-flight tracking and stale-response drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_w     <= PC_RESET[31:2];
            r_pcf_wp   <= '0;
            r_pcf_rp   <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
        end else begin
            if (redirect_valid) begin
                r_pc_w <= redirect_pc[31:2];
            end else if (w_hs) begin
                r_pc_w <= r_pc_w + 30'd1;
            end
            if (w_hs) begin
                r_pcf_wp <= r_pcf_wp + AW'(1);
            end
            if (w_resp) begin
                r_pcf_rp <= r_pcf_rp + AW'(1);
            end
            r_inflight <= r_inflight + CW'(w_hs) - CW'(w_resp);
            // Every request still outstanding after this cycle is stale.
            // Pending drops are already part of r_inflight, and no request
            // can handshake while redirect_valid is high.
            if (redirect_valid) begin
                r_drop <= r_inflight - CW'(w_resp);
            end else if (w_resp && w_drop_active) begin
                r_drop <= r_drop - CW'(1);
            end
        end
    end

    // Payload storage; validity is tracked by the pointers and counts.
    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_pcf[r_pcf_wp] <= r_pc_w;
        end
        if (w_push) begin
            r_iq[r_iq_wp] <= w_push_entry;
        end
    end

    // Instruction queue occupancy; a redirect discards everything buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iq_wp  <= '0;
            r_iq_rp  <= '0;
            r_qcount <= '0;
        end else if (redirect_valid) begin
            r_iq_wp  <= '0;
            r_iq_rp  <= '0;
            r_qcount <= '0;
        end else begin
            if (w_push) begin
                r_iq_wp <= r_iq_wp + AW'(1);
            end
            if (w_pop) begin
                r_iq_rp <= r_iq_rp + AW'(1);
            end
            r_qcount <= r_qcount + CW'(w_push) - CW'(w_pop);
        end
    end

    // IF/ID register: flush > hold > load head > bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_id    <= '0;
            r_inst_id  <= NOP_INST;
            r_valid_id <= 1'b0;
            r_bubble   <= 1'b0;
        end else begin
            r_bubble <= 1'b0;
            if (reg_FD_flush) begin
                r_valid_id <= 1'b0;
                r_inst_id  <= NOP_INST;
            end else if (reg_FD_stall || !reg_FD_EN) begin
                r_valid_id <= r_valid_id;
            end else if (!w_qempty) begin
                r_pc_id    <= w_head.pc;
                r_inst_id  <= w_head.inst;
                r_valid_id <= 1'b1;
            end else begin
                r_valid_id <= 1'b0;
                r_inst_id  <= NOP_INST;
                r_bubble   <= 1'b1;
            end
        end
    end

endmodule
